uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin scheduler that shares one UART transmitter between NUM_REQ byte producers.
- Accepts one byte per valid/ready handshake from the winning requester.
- Drives the transmitter's data and send inputs, then holds them until that frame completes.
- Sits between the application-side producers and the transmitter top level; it runs on the system clock.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width; fixed to the transmitter data width.
- SYNC_STAGES, 2, flop stages on tx_active/tx_done (they originate in the baud-clock domain).
- TIMEOUT_CYC, 1048576, watchdog limit in clock cycles (only used with TX_TIMEOUT_EN).

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester byte available.
- req_data  in  NUM_REQ*DATA_W  packed bytes; requester i occupies [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  one-hot accept pulse.
- tx_data  out  DATA_W  byte to the transmitter data input.
- tx_send  out  1  start request to the transmitter.
- tx_active  in  1  transmitter busy flag.
- tx_done  in  1  transmitter done flag.
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served.
- busy  out  1  high whenever the state is not IDLE.
- tx_error  out  1  one-cycle pulse on a watchdog abort (tied 0 without TX_TIMEOUT_EN).

Behaviour:
- Reset (async assert, sync release) forces:
  - state=IDLE; rr_ptr=0.
  - req_ready=0, tx_data=0, tx_send=0, grant_id=0, busy=0, tx_error=0.
  - Sync flops cleared to 0.
- tx_active_s and tx_done_s are the SYNC_STAGES-synchronized versions of the inputs; the FSM uses only these.
- IDLE:
  - If any req_valid is set, pick the first set bit searching from rr_ptr upward with wrap-around.
  - In the same cycle: latch that requester's req_data into tx_data, set grant_id, pulse req_ready[winner] for exactly 1 cycle, and go to START.
  - With no req_valid set, stay in IDLE with all outputs idle.
- Handshake:
  - A transfer occurs when req_valid[i] and req_ready[i] are both high.
  - The requester holds valid and data until it sees ready.
  - req_ready is asserted only in IDLE, so at most one requester is accepted per frame.
- START:
  - tx_send=1 while waiting.
  - On tx_active_s=1, drop tx_send and go to WAIT_DONE.
- WAIT_DONE:
  - tx_send=0 and tx_data is held.
  - Transition to RELEASE on tx_active_s=0 and tx_done_s=1, i.e. a done seen after active.
  - A done flag that was already high in START is ignored.
- RELEASE (1 cycle): rr_ptr = grant_id+1, wrapping NUM_REQ-1 to 0, then go to IDLE.
- Latency and throughput:
  - req_valid to req_ready: 1 cycle when the arbiter is idle.
  - Minimum gap between consecutive req_ready pulses: one frame + SYNC_STAGES + 2 cycles.
- tx_data and grant_id are stable from acceptance until RELEASE completes.
- Boundary conditions:
  - A requester dropping req_valid while another is being served loses nothing; it was not yet accepted.
  - When all requesters are valid, grants rotate 0,1,2,3,0…
  - A single requester holding valid continuously is granted back-to-back.
  - Reset mid-frame aborts the handshake immediately. The transmitter is reset separately; no byte is replayed.
- Requester bit ordering: bit 0 is index 0.

Optional Feature:
- Macro TX_TIMEOUT_EN.
- When defined:
  - A cycle counter is cleared on entry to START and runs in START and WAIT_DONE.
  - Reaching TIMEOUT_CYC-1 pulses tx_error for 1 cycle, forces tx_send=0, and goes to RELEASE, so rr_ptr advances past the stuck requester.
- When not defined: no counter is built, tx_error is constant 0, and the FSM waits indefinitely.

Decomposition:
- Shared package uart_pkg:
  - State enum (IDLE, START, WAIT_DONE, RELEASE).
  - UART_DATA_W=8.
  - Default TIMEOUT_CYC constant.
- Sub-module uart_sync: a generic SYNC_STAGES-deep single-bit synchronizer with async active-high reset, instantiated twice (active, done).
- The round-robin search is a function inside uart_tx_arbiter, not a separate module.

Test Plan:
- Single request: req_valid=4'b0010, data 0xA5 → req_ready=4'b0010 for 1 cycle, next cycle; tx_data=0xA5, grant_id=1; tx_send high until the model raises active; busy drops after done.
- All requesters valid, data 0x10..0x13 → frames go out as 0x10,0x11,0x12,0x13,0x10; rr_ptr wraps from 3 to 0.
- Requester 2 held valid continuously, others idle → back-to-back grants to 2 with no starvation; the ready gap is at least one frame.
- tx_done stuck high before START (model idle) → the FSM does not release until active 1→0 with done 1.
- Reset asserted while in WAIT_DONE → all outputs 0 asynchronously, without waiting for a clock edge; after release, req_valid=4'b1000 is granted with grant_id=3 (rr_ptr=0).
- With TX_TIMEOUT_EN and TIMEOUT_CYC=64, the model never raises active → tx_error pulses at cycle 63 after START, then the next valid requester is served.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit arbiter.
package uart_pkg;

  localparam int UART_DATA_W      = 8;
  localparam int UART_TIMEOUT_CYC = 1048576;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    START     = 2'd1,
    WAIT_DONE = 2'd2,
    RELEASE   = 2'd3
  } state_t;

endpackage

// File: rtl/uart_sync.sv
// Multi-flop single-bit synchronizer with asynchronous active-high reset.
module uart_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [SYNC_STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        r_sync[k] <= r_sync[k-1];
      end
    end
  end

  assign o_q = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte producers.
// Optional watchdog abort is built when TX_TIMEOUT_EN is defined.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = UART_DATA_W,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = UART_TIMEOUT_CYC
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_send,
  input  logic                       tx_active,
  input  logic                       tx_done,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       busy,
  output logic                       tx_error
);

  localparam int ID_W = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || DATA_W != UART_DATA_W ||
      SYNC_STAGES < 1 || TIMEOUT_CYC < 2) begin : g_bad_cfg
    $error("uart_tx_arbiter: unsupported parameter set");
  end

  state_t              r_state;
  logic [ID_W-1:0]     r_rr_ptr;
  logic [ID_W-1:0]     r_grant_id;
  logic [NUM_REQ-1:0]  r_ready;
  logic [DATA_W-1:0]   r_tx_data;
  logic                w_active_s;
  logic                w_done_s;
  logic                w_timeout;
  logic                w_any;
  logic [ID_W-1:0]     w_pick;

  // First set bit at or above ptr, wrapping; scanning far-to-near leaves the nearest.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] pick;
    logic [ID_W-1:0] idx;
    pick = ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(ptr) + k) % NUM_REQ);
      if (valid[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + 1'b1;
  endfunction

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_active (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (tx_active),
    .o_q   (w_active_s)
  );

  uart_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_done (
    .i_clk (clock),
    .i_rst (reset),
    .i_d   (tx_done),
    .o_q   (w_done_s)
  );

  assign w_any  = |req_valid;
  assign w_pick = rr_pick(req_valid, r_rr_ptr);

`ifdef TX_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_to_cnt;

  // Held at zero in IDLE so the first START cycle counts as cycle 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_to_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_to_cnt <= '0;
    end else if (r_state == START || r_state == WAIT_DONE) begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_timeout = (r_state == START || r_state == WAIT_DONE) &&
                     (r_to_cnt == CNT_W'(TIMEOUT_CYC - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_grant_id <= '0;
      r_ready    <= '0;
      r_tx_data  <= '0;
    end else begin
      r_ready <= '0;
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_tx_data  <= req_data[w_pick*DATA_W +: DATA_W];
            r_grant_id <= w_pick;
            r_ready    <= NUM_REQ'(1) << w_pick;
            r_state    <= START;
          end
        end
        START: begin
          if (w_timeout)       r_state <= RELEASE;
          else if (w_active_s) r_state <= WAIT_DONE;
        end
        // Only a done seen after active counts; a stale done during START is ignored.
        WAIT_DONE: begin
          if (w_timeout)                   r_state <= RELEASE;
          else if (!w_active_s && w_done_s) r_state <= RELEASE;
        end
        RELEASE: begin
          r_rr_ptr <= next_id(r_grant_id);
          r_state  <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = r_ready;
  assign tx_data   = r_tx_data;
  assign grant_id  = r_grant_id;
  assign tx_send   = (r_state == START) && !w_timeout;
  assign busy      = (r_state != IDLE);
  assign tx_error  = w_timeout;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter with a behavioural transmitter model.
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int SS = 2;
  localparam int TO = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [N-1:0]      req_valid = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N-1:0]      req_ready;
  logic [DW-1:0]     tx_data;
  logic              tx_send;
  logic              tx_active;
  logic              tx_done;
  logic [1:0]        grant_id;
  logic              busy;
  logic              tx_error;

  int errors = 0;
  int checks = 0;
  int err_seen = 0;

  bit       model_en   = 1'b1;
  bit       done_stuck = 1'b0;
  bit       model_busy = 1'b0;
  int       frame_len  = 8;
  logic [DW-1:0] sent_q[$];
  logic [DW-1:0] exp_q[$];

  typedef struct {
    logic [N-1:0]    valid;
    logic [N*DW-1:0] data;
    int              exp_id;
  } vec_t;

  uart_tx_arbiter #(
    .NUM_REQ     (N),
    .DATA_W      (DW),
    .SYNC_STAGES (SS),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clock     (clk),
    .reset     (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .tx_data   (tx_data),
    .tx_send   (tx_send),
    .tx_active (tx_active),
    .tx_done   (tx_done),
    .grant_id  (grant_id),
    .busy      (busy),
    .tx_error  (tx_error)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (tx_error === 1'b1) err_seen++;

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // Transmitter model: on send, logs the byte, raises active for frame_len cycles, then pulses done.
  initial begin : tx_model
    tx_active = 1'b0;
    tx_done   = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && tx_send === 1'b1 && !model_busy) begin
        model_busy = 1'b1;
        sent_q.push_back(tx_data);
        repeat (2) @(negedge clk);
        tx_active = 1'b1;
        tx_done   = done_stuck;
        repeat (frame_len) @(negedge clk);
        tx_active = 1'b0;
        tx_done   = 1'b1;
        @(negedge clk);
        tx_done    = done_stuck;
        model_busy = 1'b0;
      end else begin
        tx_done = done_stuck;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int rr_ref(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic wait_ready(input int maxc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (req_ready == '0 && cyc < maxc);
  endtask

  task automatic wait_idle(input string tag, input int maxc);
    int c;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (busy && c < maxc);
    chk({tag, "_idle"}, busy, 0);
  endtask

  task automatic wait_model_idle();
    int c;
    c = 0;
    while (model_busy && c < 500) begin
      @(negedge clk);
      c++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_model_idle();
    sent_q.delete();
  endtask

  task automatic one_frame(input logic [N-1:0] v, input logic [N*DW-1:0] d,
                           input int exp_id, input string tag);
    logic [DW-1:0] expd;
    int cyc;
    expd = d[exp_id*DW +: DW];
    @(negedge clk);
    req_valid = v;
    req_data  = d;
    wait_ready(100, cyc);
    chk({tag, "_latency"}, cyc, 1);
    chk({tag, "_ready"}, req_ready, 32'(1) << exp_id);
    chk({tag, "_grant"}, grant_id, exp_id);
    chk({tag, "_txdata"}, tx_data, expd);
    chk({tag, "_send"}, tx_send, 1);
    req_valid = '0;
    @(negedge clk);
    chk({tag, "_ready_pulse"}, req_ready, 0);
    chk({tag, "_txdata_hold"}, tx_data, expd);
    wait_idle(tag, 300);
    chk({tag, "_sent_cnt"}, sent_q.size(), 1);
    if (sent_q.size() > 0) chk({tag, "_sent_byte"}, sent_q.pop_front(), expd);
  endtask

  task automatic rnd_accept(inout int ptr_m, inout logic [DW-1:0] pend[N]);
    int e;
    if (req_ready != '0) begin
      e = rr_ref(req_valid, ptr_m);
      if (e < 0) begin
        chk("rnd_spurious_ready", req_ready, 0);
      end else begin
        chk("rnd_ready", req_ready, 32'(1) << e);
        chk("rnd_grant", grant_id, e);
        chk("rnd_txdata", tx_data, pend[e]);
        exp_q.push_back(pend[e]);
        ptr_m = (e + 1) % N;
        req_valid[e] = 1'b0;
      end
    end
  endtask

  initial begin : main
    vec_t tbl[8];
    int cyc, c, ptr_m;
    bit saw;
    logic [DW-1:0] pend[N];
    logic [DW-1:0] rot_exp[5];

    tbl[0] = '{4'b0010, 32'h0000_A500, 1};
    tbl[1] = '{4'b1111, 32'h4433_2211, 2};
    tbl[2] = '{4'b0011, 32'h0000_6655, 0};
    tbl[3] = '{4'b1001, 32'h7700_0088, 3};
    tbl[4] = '{4'b1000, 32'h9900_0000, 3};
    tbl[5] = '{4'b0001, 32'h0000_00AA, 0};
    tbl[6] = '{4'b0101, 32'h00BB_00CC, 2};
    tbl[7] = '{4'b0110, 32'h00DD_EE00, 1};

    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 0);
    chk("rst_txdata", tx_data, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_grant", grant_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", tx_error, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int e = 0; e < 8; e++) one_frame(tbl[e].valid, tbl[e].data, tbl[e].exp_id, $sformatf("vec%0d", e));

    // All requesters valid: rotation 0,1,2,3,0 from a fresh pointer.
    do_reset();
    @(negedge clk);
    req_valid = '1;
    req_data  = 32'h1312_1110;
    for (int k = 0; k < 5; k++) begin
      wait_ready(300, cyc);
      chk($sformatf("rot%0d_ready", k), req_ready, 32'(1) << (k % N));
      chk($sformatf("rot%0d_grant", k), grant_id, k % N);
      if (k > 0) chk($sformatf("rot%0d_gap_ok", k), cyc >= frame_len + SS + 2, 1);
    end
    req_valid = '0;
    wait_idle("rot", 300);
    rot_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    chk("rot_sent_cnt", sent_q.size(), 5);
    for (int k = 0; k < 5; k++) if (k < sent_q.size()) chk($sformatf("rot_sent%0d", k), sent_q[k], rot_exp[k]);
    sent_q.delete();

    // Single requester held valid: granted back-to-back.
    @(negedge clk);
    req_valid = 4'b0100;
    req_data  = 32'h005A_0000;
    for (int k = 0; k < 3; k++) begin
      wait_ready(300, cyc);
      chk($sformatf("b2b%0d_ready", k), req_ready, 4'b0100);
      if (k > 0) chk($sformatf("b2b%0d_gap_ok", k), cyc >= frame_len + SS + 2, 1);
    end
    req_valid = '0;
    wait_idle("b2b", 300);
    chk("b2b_sent_cnt", sent_q.size(), 3);
    sent_q.delete();

    // Done flag stuck high before the frame starts.
    done_stuck = 1'b1;
    repeat (4) @(negedge clk);
    req_valid = 4'b0001;
    req_data  = 32'h0000_00C3;
    wait_ready(100, cyc);
    chk("stuck_ready", req_ready, 4'b0001);
    req_valid = '0;
    saw = 1'b0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
      if (tx_active) saw = 1'b1;
    end while (busy && c < 300);
    chk("stuck_saw_active", saw, 1);
    chk("stuck_active_low_at_release", tx_active, 0);
    chk("stuck_idle", busy, 0);
    done_stuck = 1'b0;
    wait_model_idle();
    sent_q.delete();

    // Reset asserted in WAIT_DONE clears outputs without a clock edge.
    frame_len = 20;
    @(negedge clk);
    req_valid = 4'b0010;
    req_data  = 32'h0000_E700;
    wait_ready(100, cyc);
    req_valid = '0;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!tx_active && c < 50);
    repeat (SS + 3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_txdata", tx_data, 8'hE7);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_send", tx_send, 0);
    chk("async_rst_ready", req_ready, 0);
    chk("async_rst_txdata", tx_data, 0);
    chk("async_rst_grant", grant_id, 0);
    chk("async_rst_error", tx_error, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_model_idle();
    sent_q.delete();
    frame_len = 8;
    one_frame(4'b1000, 32'h3C00_0000, 3, "post_rst");

    // Randomized producers against the round-robin reference.
    do_reset();
    ptr_m = 0;
    for (int i = 0; i < N; i++) pend[i] = '0;
    exp_q.delete();
    for (int t = 0; t < 1500; t++) begin
      @(negedge clk);
      rnd_accept(ptr_m, pend);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          pend[i] = 8'($urandom);
          req_data[i*DW +: DW] = pend[i];
          req_valid[i] = 1'b1;
        end
      end
      if ($urandom_range(0, 31) == 0) frame_len = 6 + $urandom_range(0, 4);
    end
    c = 0;
    while ((req_valid != '0 || busy) && c < 3000) begin
      @(negedge clk);
      c++;
      rnd_accept(ptr_m, pend);
    end
    chk("rnd_drained", req_valid, 0);
    wait_model_idle();
    chk("rnd_sent_cnt", sent_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size(); k++) if (k < sent_q.size()) chk($sformatf("rnd_sent%0d", k), sent_q[k], exp_q[k]);
    sent_q.delete();
    frame_len = 8;

`ifdef TX_TIMEOUT_EN
    // Transmitter never starts: watchdog aborts and the next requester is served.
    do_reset();
    model_en = 1'b0;
    @(negedge clk);
    req_valid = 4'b0101;
    req_data  = 32'h0022_0011;
    wait_ready(100, cyc);
    chk("to_first_ready", req_ready, 4'b0001);
    req_valid = 4'b0100;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!tx_error && c < 200);
    chk("to_cycle", c, TO - 1);
    chk("to_send_low", tx_send, 0);
    model_en = 1'b1;
    @(negedge clk);
    chk("to_pulse_width", tx_error, 0);
    wait_ready(100, cyc);
    chk("to_next_ready", req_ready, 4'b0100);
    chk("to_next_grant", grant_id, 2);
    chk("to_next_txdata", tx_data, 8'h22);
    req_valid = '0;
    wait_idle("to", 300);
    chk("to_sent_cnt", sent_q.size(), 1);
    if (sent_q.size() > 0) chk("to_sent_byte", sent_q.pop_front(), 8'h22);
`else
    chk("no_tx_error", err_seen, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
